// File: rtl/full_adder_pkg.sv
// Shared constants and types for the registered ripple adder.
// Optional overflow output is enabled by FA4_OVF_EN.
package full_adder_pkg;

  localparam int FA_WIDTH_DEFAULT = 4;

  typedef logic [FA_WIDTH_DEFAULT:0] fa_sum_t;

endpackage

// File: rtl/full_adder_1bit.sv
// One ripple-chain cell: sum and majority carry.
// Purely combinational; registered by the parent.
module full_adder_1bit
  import full_adder_pkg::*;
(
  input  logic i_x,
  input  logic i_y,
  input  logic i_ci,
  output logic o_sum,
  output logic o_co
);

  assign o_sum = i_x ^ i_y ^ i_ci;
  assign o_co  = (i_x & i_y) | (i_x & i_ci) | (i_y & i_ci);

endmodule

// File: rtl/full_adder_4bit_bh.sv
// Registered WIDTH-bit ripple adder with carry, valid flag.
// Define FA4_OVF_EN to add the registered signed-overflow port ovf.
module full_adder_4bit_bh
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             valid
`ifdef FA4_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic             r_valid;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_1bit u_fa (
      .i_x   (a[i]),
      .i_y   (b[i]),
      .i_ci  (w_carry[i]),
      .o_sum (w_sum[i]),
      .o_co  (w_carry[i+1])
    );
  end

  // Capture sum/carry on enable; hold otherwise; valid tracks en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s     <= '0;
      r_c     <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= en;
      if (en) begin
        r_s <= w_sum;
        r_c <= w_carry[WIDTH];
      end
    end
  end

  assign s     = r_s;
  assign c     = r_c;
  assign valid = r_valid;

`ifdef FA4_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into MSB cell differs from carry out.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_ovf <= 1'b0;
    else if (en)
      r_ovf <= w_carry[WIDTH-1] ^ w_carry[WIDTH];
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_full_adder_4bit_bh.sv
// Self-checking bench for full_adder_4bit_bh.
// Arithmetic reference model; FA4_OVF_EN also checks ovf.
module tb_full_adder_4bit_bh;
  import full_adder_pkg::*;

  localparam int W = FA_WIDTH_DEFAULT;
  localparam int MAXU = (1 << W) - 1;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] s;
  logic         c;
  logic         valid;
`ifdef FA4_OVF_EN
  logic         ovf;
`endif

  int n_err = 0;
  int n_chk = 0;

  logic [W-1:0] m_s;
  logic         m_c;
  logic         m_v;
  logic         m_o;

  full_adder_4bit_bh #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .s     (s),
    .c     (c),
    .valid (valid)
`ifdef FA4_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic per clock edge.
  task automatic model(input logic r, input logic e,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci);
    int t;
    int sx;
    int sy;
    int ts;
    if (!r) begin
      m_s = '0; m_c = 1'b0; m_v = 1'b0; m_o = 1'b0;
    end else if (e) begin
      t   = int'(x) + int'(y) + int'(ci);
      m_s = W'(t % (MAXU + 1));
      m_c = (t > MAXU);
      m_v = 1'b1;
      sx  = x[W-1] ? int'(x) - (MAXU + 1) : int'(x);
      sy  = y[W-1] ? int'(y) - (MAXU + 1) : int'(y);
      ts  = sx + sy + int'(ci);
      m_o = (ts > SMAX) || (ts < SMIN);
    end else begin
      m_v = 1'b0;
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic e,
                     input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic ci);
    rst_n = r; en = e; a = x; b = y; cin = ci;
    model(r, e, x, y, ci);
    @(posedge clk);
    #1;
    chk({tag, ".s"}, 32'(s), 32'(m_s));
    chk({tag, ".c"}, 32'(c), 32'(m_c));
    chk({tag, ".v"}, 32'(valid), 32'(m_v));
`ifdef FA4_OVF_EN
    chk({tag, ".o"}, 32'(ovf), 32'(m_o));
`endif
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2;

    // Reset for 2 cycles with all-ones operands and en high.
    cyc("rst0", 1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
    cyc("rst1", 1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
    chk("rst_s_const", 32'(s), 32'h0);
    chk("rst_v_const", 32'(valid), 32'h0);

    // First enabled cycle after reset, wrap.
    cyc("wrap", 1'b1, 1'b1, 4'hF, 4'h1, 1'b0);
    chk("wrap_s_const", 32'(s), 32'h0);
    chk("wrap_c_const", 32'(c), 32'h1);
    cyc("fff", 1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
    chk("fff_s_const", 32'(s), 32'hF);

    // Exhaustive sweep: a outer, b middle, cin inner.
    for (int i = 0; i <= MAXU; i++)
      for (int j = 0; j <= MAXU; j++)
        for (int k = 0; k < 2; k++)
          cyc("sweep", 1'b1, 1'b1, W'(i), W'(j), k[0]);

    // Hold with changing and unknown operands.
    cyc("hold_cap", 1'b1, 1'b1, 4'h3, 4'h4, 1'b1);
    cyc("hold1", 1'b1, 1'b0, 4'hA, 4'h7, 1'b1);
    cyc("hold2", 1'b1, 1'b0, 4'hx, 4'hx, 1'bx);
    chk("hold_s_const", 32'(s), 32'h8);
    chk("hold_c_const", 32'(c), 32'h0);
    chk("hold_v_const", 32'(valid), 32'h0);

    // Reset beats a pending capture.
    cyc("mid_pre", 1'b1, 1'b1, 4'hE, 4'h5, 1'b0);
    cyc("mid_rst", 1'b0, 1'b1, 4'h9, 4'h9, 1'b0);
    chk("mid_s_const", 32'(s), 32'h0);
    chk("mid_c_const", 32'(c), 32'h0);
    cyc("mid_post", 1'b1, 1'b1, 4'h9, 4'h9, 1'b0);

    // Signed-overflow corners.
    cyc("ovf_71", 1'b1, 1'b1, 4'h7, 4'h1, 1'b0);
    cyc("ovf_88", 1'b1, 1'b1, 4'h8, 4'h8, 1'b0);
    cyc("ovf_32", 1'b1, 1'b1, 4'h3, 4'h2, 1'b0);
`ifdef FA4_OVF_EN
    cyc("ovf_71b", 1'b1, 1'b1, 4'h7, 4'h1, 1'b0);
    chk("ovf_71_const", 32'(ovf), 32'h1);
    cyc("ovf_88b", 1'b1, 1'b1, 4'h8, 4'h8, 1'b0);
    chk("ovf_88_const", 32'(ovf), 32'h1);
    cyc("ovf_32b", 1'b1, 1'b1, 4'h3, 4'h2, 1'b0);
    chk("ovf_32_const", 32'(ovf), 32'h0);
`endif

    // Random traffic with sparse resets and enable gaps.
    for (int n = 0; n < 400; n++)
      cyc("rand",
          ($urandom_range(0, 19) != 0),
          ($urandom_range(0, 3) != 0),
          W'($urandom), W'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/full_adder_4bit_bh.md
FULL_ADDER_4BIT_BH -- requirements
Module: full_adder_4bit_bh

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the operand and sum width.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit, SHALL be the reset: synchronous, active-low.
REQ-004 Port en, input, 1 bit, SHALL be the capture enable; 1 means the operands are valid this cycle.
REQ-005 Port a, input, WIDTH bits, SHALL be addend A (unsigned).
REQ-006 Port b, input, WIDTH bits, SHALL be addend B (unsigned).
REQ-007 Port cin, input, 1 bit, SHALL be the carry-in.
REQ-008 Port s, output, WIDTH bits, SHALL be the registered sum.
REQ-009 Port c, output, 1 bit, SHALL be the registered carry-out.
REQ-010 Port valid, output, 1 bit, SHALL be high while s and c hold a result captured from the previous enabled cycle.
REQ-011 Port ovf, output, 1 bit, SHALL be present only when FA4_OVF_EN is defined.

Function
REQ-012 On a rising clk edge with rst_n=1 and en=1, {c,s} SHALL load a+b+cin, computed at WIDTH+1 bits with no truncation before the carry.
REQ-013 Latency SHALL be exactly one cycle: operands sampled at edge N appear on s and c after edge N.
REQ-014 On a rising clk edge with rst_n=1 and en=0, s, c and ovf SHALL hold their values, and valid SHALL go to 0.
REQ-015 On a rising clk edge with rst_n=1 and en=1, valid SHALL go to 1.
REQ-016 Wrap-around: when a+b+cin exceeds 2^WIDTH-1, s SHALL be the low WIDTH bits and c SHALL be 1. Example: F+F+1 gives s=F, c=1.
REQ-017 The sum SHALL be formed by a ripple chain of WIDTH 1-bit full-adder cells; the carry into cell 0 is cin, and c is the carry out of cell WIDTH-1.
REQ-018 There SHALL be no combinational path from any input to any output.
REQ-019 X on an operand while en=0 SHALL NOT affect the outputs.

Reset
REQ-020 On a rising clk edge with rst_n=0, s, c, valid and ovf SHALL all become 0, regardless of en.
REQ-021 Reset SHALL take priority over en; reset asserted mid-stream SHALL discard the pending capture.
REQ-022 In the first enabled cycle after rst_n returns to 1, the block SHALL capture normally.

Configuration
REQ-023 With macro FA4_OVF_EN defined, port ovf SHALL exist and SHALL register two's-complement overflow under the REQ-012 and REQ-014 rules: carry into the MSB cell XOR carry out of the MSB cell.
REQ-024 Without FA4_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-025 A package full_adder_pkg SHALL hold the constant FA_WIDTH_DEFAULT=4 and a typedef for the WIDTH+1-bit sum-with-carry result.
REQ-026 A sub-module full_adder_1bit SHALL implement one cell:
- sum = x XOR y XOR ci
- co = majority(x, y, ci)
REQ-027 full_adder_1bit SHALL be instantiated WIDTH times by a generate loop.

Verification
REQ-028 Reset check: rst_n=0 for 2 cycles with a=F, b=F, cin=1, en=1 SHALL give s=0, c=0, valid=0.
REQ-029 Wrap check: a=F, b=1, cin=0, en=1 SHALL give s=0, c=1, valid=1 one cycle later.
REQ-030 Exhaustive sweep: all 512 combinations of a, b and cin (a outer loop, b middle, cin inner) with en=1 SHALL give {c,s}=a+b+cin one cycle after each input.
REQ-031 Hold check: capture a=3, b=4, cin=1 (result s=8, c=0), then hold en=0 while a and b change, SHALL give s=8 and c=0 held with valid=0.
REQ-032 Mid-stream reset: rst_n=0 in the same cycle as en=1 with a=9, b=9 SHALL give s=0 and c=0, not s=2 and c=1.
REQ-033 Overflow check (FA4_OVF_EN defined): a=7, b=1, cin=0 SHALL give ovf=1; a=8, b=8, cin=0 SHALL give ovf=1 and c=1; a=3, b=2 SHALL give ovf=0.
